// File: rtl/regtest_pkg.sv
// Shared definitions for the register-file self-test sequencer.
// Holds the sequencer state and mode encodings, the datapath opcode
// constants, the instruction field positions and the instruction packer.
// The optional self-check feature is selected by REGTEST_SELF_CHECK_EN.
package regtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD0 = 3'd1,
      ST_LOAD1 = 3'd2,
      ST_EXEC  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      MODE_FIB_ADD = 2'b00,
      MODE_FIB_SUB = 2'b01,
      MODE_DOUBLE  = 2'b10
   } mode_e;

   localparam logic [3:0] OP_HI_RTYPE = 4'b0000;
   localparam logic [3:0] OP_LO_ADD   = 4'b0101;
   localparam logic [3:0] OP_LO_SUB   = 4'b1001;

   localparam int INSTR_OP_HI_LSB = 12;
   localparam int INSTR_SRC_A_LSB = 8;
   localparam int INSTR_OP_LO_LSB = 4;
   localparam int INSTR_SRC_B_LSB = 0;

   // The unused encoding 2'b11 runs as a Fibonacci add.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      case (raw)
         2'b01:   return MODE_FIB_SUB;
         2'b10:   return MODE_DOUBLE;
         default: return MODE_FIB_ADD;
      endcase
   endfunction

   function automatic logic [15:0] make_instr(input logic [3:0] op_hi,
                                              input logic [3:0] src_a,
                                              input logic [3:0] op_lo,
                                              input logic [3:0] src_b);
      logic [15:0] word;
      word = '0;
      word[INSTR_OP_HI_LSB +: 4] = op_hi;
      word[INSTR_SRC_A_LSB +: 4] = src_a;
      word[INSTR_OP_LO_LSB +: 4] = op_lo;
      word[INSTR_SRC_B_LSB +: 4] = src_b;
      return word;
   endfunction

endpackage

// File: rtl/regtest_expect.sv
// Expected-value model and compare for the register-file self-test.
// Only instantiated when REGTEST_SELF_CHECK_EN is defined.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   mode, seed      run configuration latched by the sequencer
//   chk_valid       rout holds the result of write number chk_idx this cycle
//   chk_idx         register index being checked (checked in order 0,1,2,...)
//   rout            datapath result bus
//   mismatch        rout differs from the model value this cycle
module regtest_expect
   import regtest_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  mode_e             mode,
   input  logic [DATA_W-1:0] seed,
   input  logic              chk_valid,
   input  logic [3:0]        chk_idx,
   input  logic [DATA_W-1:0] rout,
   output logic              mismatch
);

   // hist1 holds e[i-1], hist2 holds e[i-2] for the index about to be checked.
   logic [DATA_W-1:0] hist1_q, hist1_d;
   logic [DATA_W-1:0] hist2_q, hist2_d;
   logic [DATA_W-1:0] expect_val;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      hist1_d    = hist1_q;
      hist2_d    = hist2_q;
      expect_val = seed;
      if (chk_idx >= 4'd2) begin
         case (mode)
            MODE_FIB_SUB: expect_val = hist1_q - hist2_q;
            MODE_DOUBLE:  expect_val = hist1_q + hist1_q;
            default:      expect_val = hist1_q + hist2_q;
         endcase
      end
      // Advance the history from the model, never from rout, so one bad
      // value does not poison the following expectations.
      if (chk_valid) begin
         hist1_d = expect_val;
         hist2_d = hist1_q;
      end
      mismatch = chk_valid && (rout != expect_val);
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // flops sample their inputs from before the clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist1_q <= '0;
         hist2_q <= '0;
      end else begin
         hist1_q <= hist1_d;
         hist2_q <= hist2_d;
      end
   end

endmodule

// File: rtl/regfile_test_seq.sv
// Register-file / datapath self-test sequencer.
// On start it loads the latched seed into r0 and r1, then issues one ALU
// instruction per cycle filling r2..r(NUM_REGS-1) with a recurrence.
// Optional feature macro: REGTEST_SELF_CHECK_EN builds in the model and
// compare; without it pass goes to 1 at the end of every run and fail_idx
// is tied to 0.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start               level, sampled only while idle
//   mode, seed          run configuration, latched on start
//   rout                datapath result (value written by previous command)
//   instr               {op-hi, src A, op-lo, src B}
//   reg_en              one-hot destination write enable
//   load_en, load_data  write the latched seed instead of the ALU result
//   busy, done          running / one-cycle end-of-run pulse
//   pass, fail_idx      result of the last run, first failing register
//   state               displayed state encoding
module regfile_test_seq
   import regtest_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [DATA_W-1:0]   seed,
   input  logic [DATA_W-1:0]   rout,
   output logic [15:0]         instr,
   output logic [NUM_REGS-1:0] reg_en,
   output logic                load_en,
   output logic [DATA_W-1:0]   load_data,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [3:0]          fail_idx,
   output logic [2:0]          state
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   // The sequencer runs one cycle ahead of the registered outputs, which
   // are decoded from it, so nothing combinational reaches a port.
   state_e              seq_q, seq_d;
   logic [3:0]          idx_q, idx_d;
   mode_e               mode_q, mode_d;
   logic [DATA_W-1:0]   seed_q, seed_d;

   logic [15:0]         instr_q, instr_d;
   logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
   logic                load_en_q, load_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   state_e              state_q, state_d;

   // busy_q is still high for the one cycle where the sequencer is already
   // idle but the outputs still show DONE; start must be ignored there too.
   logic start_take;
   assign start_take = (seq_q == ST_IDLE) && !busy_q && start;

   always_comb begin
      seq_d  = seq_q;
      idx_d  = idx_q;
      mode_d = mode_q;
      seed_d = seed_q;
      case (seq_q)
         ST_IDLE: begin
            if (start_take) begin
               seq_d  = ST_LOAD0;
               idx_d  = 4'd0;
               mode_d = decode_mode(mode);
               seed_d = seed;
            end
         end
         ST_LOAD0: begin
            seq_d = ST_LOAD1;
            idx_d = idx_q + 4'd1;
         end
         ST_LOAD1: begin
            seq_d = ST_EXEC;
            idx_d = idx_q + 4'd1;
         end
         ST_EXEC: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == LAST_IDX) seq_d = ST_DRAIN;
         end
         ST_DRAIN: seq_d = ST_DONE;
         default:  seq_d = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_d   = '0;
      reg_en_d  = '0;
      load_en_d = 1'b0;
      case (seq_q)
         ST_LOAD0, ST_LOAD1: begin
            load_en_d = 1'b1;
            reg_en_d  = NUM_REGS'(1) << idx_q;
         end
         ST_EXEC: begin
            reg_en_d = NUM_REGS'(1) << idx_q;
            case (mode_q)
               MODE_FIB_SUB: instr_d = make_instr(OP_HI_RTYPE, idx_q - 4'd1, OP_LO_SUB, idx_q - 4'd2);
               MODE_DOUBLE:  instr_d = make_instr(OP_HI_RTYPE, idx_q - 4'd1, OP_LO_ADD, idx_q - 4'd1);
               default:      instr_d = make_instr(OP_HI_RTYPE, idx_q - 4'd2, OP_LO_ADD, idx_q - 4'd1);
            endcase
         end
         default: ;
      endcase
      busy_d  = (seq_q != ST_IDLE);
      done_d  = (seq_q == ST_DONE);
      state_d = seq_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seq_q     <= ST_IDLE;
         idx_q     <= '0;
         mode_q    <= MODE_FIB_ADD;
         seed_q    <= '0;
         instr_q   <= '0;
         reg_en_q  <= '0;
         load_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         state_q   <= ST_IDLE;
      end else begin
         seq_q     <= seq_d;
         idx_q     <= idx_d;
         mode_q    <= mode_d;
         seed_q    <= seed_d;
         instr_q   <= instr_d;
         reg_en_q  <= reg_en_d;
         load_en_q <= load_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         state_q   <= state_d;
      end
   end

`ifdef REGTEST_SELF_CHECK_EN
   // A command shown on the outputs is written at the next edge and its
   // result is on rout the cycle after, so the compare trails by two stages.
   logic       cmd_valid_q, cmd_valid_d;
   logic [3:0] cmd_idx_q, cmd_idx_d;
   logic       chk_valid_q;
   logic [3:0] chk_idx_q;
   logic [3:0] fail_idx_q, fail_idx_d;
   logic       mismatch;

   regtest_expect #(.DATA_W(DATA_W)) u_expect (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode_q),
      .seed      (seed_q),
      .chk_valid (chk_valid_q),
      .chk_idx   (chk_idx_q),
      .rout      (rout),
      .mismatch  (mismatch)
   );

   always_comb begin
      cmd_valid_d = (seq_q == ST_LOAD0) || (seq_q == ST_LOAD1) || (seq_q == ST_EXEC);
      cmd_idx_d   = idx_q;
      pass_d      = pass_q;
      fail_idx_d  = fail_idx_q;
      if (start_take) begin
         pass_d     = 1'b1;
         fail_idx_d = 4'd0;
      end else if (mismatch && pass_q) begin
         // Only the first mismatch of a run is recorded.
         pass_d     = 1'b0;
         fail_idx_d = chk_idx_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_valid_q <= 1'b0;
         cmd_idx_q   <= '0;
         chk_valid_q <= 1'b0;
         chk_idx_q   <= '0;
         fail_idx_q  <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_idx_q   <= cmd_idx_d;
         chk_valid_q <= cmd_valid_q;
         chk_idx_q   <= cmd_idx_q;
         fail_idx_q  <= fail_idx_d;
      end
   end

   assign fail_idx = fail_idx_q;
`else
   logic unused_rout;
   assign unused_rout = ^rout;

   always_comb begin
      pass_d = pass_q;
      if (start_take || (seq_q == ST_DONE)) pass_d = 1'b1;
   end

   assign fail_idx = 4'd0;
`endif

   assign instr     = instr_q;
   assign reg_en    = reg_en_q;
   assign load_en   = load_en_q;
   assign load_data = seed_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign state     = state_q;

endmodule
